// File: rtl/comparator_pkg.sv
// Shared definitions for the comparator family.
// Contents:
//   cmp_state_e : FSM state encoding (IDLE = 0, SCAN = 1, DONE = 2)
//   idx_width() : bit width of a bit-index counter for a given operand width
package comparator_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } cmp_state_e;

   // ceil(log2(w)), never less than one bit so WIDTH = 1 still has a counter
   function automatic int idx_width(input int w);
      return (w <= 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/comparator_1b.sv
// Single-bit magnitude comparator.
// Ports:
//   a, b : input bits
//   gt   : a = 1, b = 0
//   eq   : a = b
//   lt   : a = 0, b = 1
module comparator_1b (
   input  logic a,
   input  logic b,
   output logic gt,
   output logic eq,
   output logic lt
);

   assign gt = a & ~b;
   assign lt = ~a & b;
   assign eq = ~(a ^ b);

endmodule

// File: rtl/comparator_serial_nb.sv
// Bit-serial magnitude comparator, MSB first, one bit per clock.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : request a comparison (accepted in IDLE or DONE)
//   signed_mode  : 0 = unsigned, 1 = two's complement (sampled with start)
//   A, B         : operands (sampled with start)
//   busy         : comparison in progress
//   done         : one-cycle pulse when the result flags become valid
//   A_greater_B, A_equal_B, A_less_B : registered one-hot result flags
module comparator_serial_nb
   import comparator_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             A_greater_B,
   output logic             A_equal_B,
   output logic             A_less_B
);

   localparam int            IW      = idx_width(WIDTH);
   localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

   cmp_state_e       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             sgn_q, sgn_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             found_q, found_d;    // a difference has been seen
   logic             dec_gt_q, dec_gt_d;  // decision taken at the first difference
   logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;

   logic bit_gt, bit_eq, bit_lt;
   logic at_msb, bit_diff, bit_dec_gt, new_found, new_dec_gt, finish;

   comparator_1b u_bit (
      .a  (a_q[idx_q]),
      .b  (b_q[idx_q]),
      .gt (bit_gt),
      .eq (bit_eq),
      .lt (bit_lt)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sgn_d    = sgn_q;
      idx_d    = idx_q;
      found_d  = found_q;
      dec_gt_d = dec_gt_q;
      gt_d     = gt_q;
      eq_d     = eq_q;
      lt_d     = lt_q;

      at_msb     = (idx_q == IDX_MSB);
      bit_diff   = ~bit_eq;
      // In signed mode the sign bit carries negative weight, so a 1 there
      // means "smaller": swap the sense of the decision on the MSB only.
      bit_dec_gt = (sgn_q && at_msb) ? bit_lt : bit_gt;
      // Once a decision is recorded, lower bits never override it.
      new_found  = found_q | bit_diff;
      new_dec_gt = found_q ? dec_gt_q : bit_dec_gt;
      finish     = (idx_q == '0) || (EARLY_EXIT && bit_diff);

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d      = A;
               b_d      = B;
               sgn_d    = signed_mode;
               idx_d    = IDX_MSB;
               found_d  = 1'b0;
               dec_gt_d = 1'b0;
               gt_d     = 1'b0;
               eq_d     = 1'b0;
               lt_d     = 1'b0;
               state_d  = SCAN;
            end else begin
               state_d = IDLE;
            end
         end
         SCAN: begin
            found_d  = new_found;
            dec_gt_d = new_dec_gt;
            if (finish) begin
               gt_d    = new_found & new_dec_gt;
               lt_d    = new_found & ~new_dec_gt;
               eq_d    = ~new_found;
               state_d = DONE;
            end else begin
               // only reached with idx_q > 0, so the counter cannot wrap
               idx_d = idx_q - IW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         sgn_q    <= 1'b0;
         idx_q    <= '0;
         found_q  <= 1'b0;
         dec_gt_q <= 1'b0;
         gt_q     <= 1'b0;
         eq_q     <= 1'b0;
         lt_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sgn_q    <= sgn_d;
         idx_q    <= idx_d;
         found_q  <= found_d;
         dec_gt_q <= dec_gt_d;
         gt_q     <= gt_d;
         eq_q     <= eq_d;
         lt_q     <= lt_d;
      end
   end

   assign busy        = (state_q == SCAN);
   assign done        = (state_q == DONE);
   assign A_greater_B = gt_q;
   assign A_equal_B   = eq_q;
   assign A_less_B    = lt_q;

endmodule

// File: tb/tb_comparator_serial_nb.sv
// Bench for comparator_serial_nb: three instances share the stimulus
//   u_ee : WIDTH = 8, EARLY_EXIT = 1
//   u_ce : WIDTH = 8, EARLY_EXIT = 0
//   u_w1 : WIDTH = 1, EARLY_EXIT = 1 (fed with bit 0 of the operands)
module tb_comparator_serial_nb;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       signed_mode = 1'b0;
   logic [7:0] A = 8'h00;
   logic [7:0] B = 8'h00;

   logic busy_ee, done_ee, gt_ee, eq_ee, lt_ee;
   logic busy_ce, done_ce, gt_ce, eq_ce, lt_ce;
   logic busy_w1, done_w1, gt_w1, eq_w1, lt_w1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   comparator_serial_nb #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_ee (
      .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .A(A), .B(B),
      .busy(busy_ee), .done(done_ee), .A_greater_B(gt_ee), .A_equal_B(eq_ee), .A_less_B(lt_ee));

   comparator_serial_nb #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_ce (
      .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .A(A), .B(B),
      .busy(busy_ce), .done(done_ce), .A_greater_B(gt_ce), .A_equal_B(eq_ce), .A_less_B(lt_ce));

   comparator_serial_nb #(.WIDTH(1), .EARLY_EXIT(1'b1)) u_w1 (
      .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .A(A[0]), .B(B[0]),
      .busy(busy_w1), .done(done_w1), .A_greater_B(gt_w1), .A_equal_B(eq_w1), .A_less_B(lt_w1));

   typedef struct {
      string      name;
      logic [7:0] a;
      logic [7:0] b;
      logic       sm;
      logic       gt;
      logic       eq;
      logic       lt;
      int         k;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference: compare the operands as integers of width w, returns {gt,eq,lt}
   function automatic logic [2:0] ref_cmp(input logic [63:0] a, input logic [63:0] b,
                                          input int w, input logic sm);
      longint signed va, vb;
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      va = longint'(a & mask);
      vb = longint'(b & mask);
      if (sm && a[w-1]) va = va - (longint'(1) << w);
      if (sm && b[w-1]) vb = vb - (longint'(1) << w);
      if (va > vb)       return 3'b100;
      else if (va == vb) return 3'b010;
      else               return 3'b001;
   endfunction

   // Reference: number of bits examined with early exit
   function automatic int ref_k(input logic [63:0] a, input logic [63:0] b, input int w);
      for (int i = w - 1; i >= 0; i--)
         if (a[i] !== b[i]) return w - i;
      return w;
   endfunction

   task automatic do_start(input logic [7:0] a, input logic [7:0] b, input logic sm);
      @(negedge clk);
      A = a;
      B = b;
      signed_mode = sm;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_compare(input string nm, input logic [7:0] a, input logic [7:0] b,
                              input logic sm, input logic egt, input logic eeq,
                              input logic elt, input int ek);
      int k_ee, k_ce, k_w1, n_ee, n_ce, n_w1;
      logic [2:0] f_ee, f_ce, f_w1, r1;
      logic [2:0] bz;
      k_ee = -1; k_ce = -1; k_w1 = -1;
      n_ee = 0;  n_ce = 0;  n_w1 = 0;
      f_ee = '0; f_ce = '0; f_w1 = '0;
      bz = 3'b111;
      r1 = ref_cmp({63'd0, a[0]}, {63'd0, b[0]}, 1, sm);
      do_start(a, b, sm);
      check({nm, " busy_after_start"}, {busy_ee, busy_ce, busy_w1}, 3'b111);
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk);
         #1;
         if (done_ee) begin
            n_ee++;
            if (k_ee < 0) begin k_ee = e; f_ee = {gt_ee, eq_ee, lt_ee}; bz[2] = busy_ee; end
         end
         if (done_ce) begin
            n_ce++;
            if (k_ce < 0) begin k_ce = e; f_ce = {gt_ce, eq_ce, lt_ce}; bz[1] = busy_ce; end
         end
         if (done_w1) begin
            n_w1++;
            if (k_w1 < 0) begin k_w1 = e; f_w1 = {gt_w1, eq_w1, lt_w1}; bz[0] = busy_w1; end
         end
      end
      check({nm, " ee_latency"}, k_ee, ek);
      check({nm, " ee_flags"}, f_ee, {egt, eeq, elt});
      check({nm, " ce_latency"}, k_ce, 8);
      check({nm, " ce_flags"}, f_ce, {egt, eeq, elt});
      check({nm, " w1_latency"}, k_w1, 1);
      check({nm, " w1_flags"}, f_w1, r1);
      check({nm, " done_pulses"}, {n_ee[3:0], n_ce[3:0], n_w1[3:0]}, 12'h111);
      check({nm, " busy_at_done"}, bz, 3'b000);
      check({nm, " flags_hold"}, {gt_ee, eq_ee, lt_ee, gt_ce, eq_ce, lt_ce},
            {egt, eeq, elt, egt, eeq, elt});
   endtask

   initial begin
      int k;
      int n;
      logic [2:0] f;
      logic [7:0] ra, rb;
      logic       rs;
      logic [2:0] rr;

      tbl[0] = '{"a5_a4_u",   8'hA5, 8'hA4, 1'b0, 1'b1, 1'b0, 1'b0, 8};
      tbl[1] = '{"80_01_u",   8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      tbl[2] = '{"80_01_s",   8'h80, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1};
      tbl[3] = '{"3c_3c_u",   8'h3C, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8};
      tbl[4] = '{"ff_00_s",   8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1};
      tbl[5] = '{"7f_80_s",   8'h7F, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1};

      // power-up reset
      #1 rst = 1'b1;
      #1;
      check("reset_outputs",
            {busy_ee, done_ee, gt_ee, eq_ee, lt_ee, busy_ce, done_ce, gt_ce, eq_ce, lt_ce,
             busy_w1, done_w1, gt_w1, eq_w1, lt_w1}, 15'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++)
         run_compare(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].sm,
                     tbl[i].gt, tbl[i].eq, tbl[i].lt, tbl[i].k);

      // start during SCAN is ignored
      k = -1; n = 0; f = '0;
      do_start(8'h01, 8'h00, 1'b0);
      for (int e = 1; e <= 12; e++) begin
         @(negedge clk);
         if (e == 2) begin A = 8'h00; B = 8'h01; start = 1'b1; end
         else start = 1'b0;
         @(posedge clk);
         #1;
         if (done_ee) begin n++; if (k < 0) begin k = e; f = {gt_ee, eq_ee, lt_ee}; end end
      end
      start = 1'b0;
      check("ignored_start latency", k, 8);
      check("ignored_start pulses", n, 1);
      check("ignored_start flags", f, 3'b100);
      check("ignored_start ce_flags", {gt_ce, eq_ce, lt_ce}, 3'b100);

      // new start during the done cycle is accepted and clears the flags
      do_start(8'h80, 8'h01, 1'b0);
      @(posedge clk);
      #1;
      check("done_restart first_done", {done_ee, gt_ee, eq_ee, lt_ee}, 4'b1100);
      @(negedge clk);
      A = 8'h3C; B = 8'h3C; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("done_restart cleared", {busy_ee, done_ee, gt_ee, eq_ee, lt_ee}, 5'b10000);
      k = -1; f = '0;
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk);
         #1;
         if (done_ee && k < 0) begin k = e; f = {gt_ee, eq_ee, lt_ee}; end
      end
      check("done_restart latency", k, 8);
      check("done_restart flags", f, 3'b010);

      // asynchronous reset in the middle of a scan
      do_start(8'h0F, 8'h0E, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_reset outputs",
            {busy_ee, done_ee, gt_ee, eq_ee, lt_ee, busy_ce, done_ce, gt_ce, eq_ce, lt_ce},
            10'd0);
      n = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (done_ee || done_ce || done_w1) n++;
      end
      @(negedge clk);
      rst = 1'b0;
      for (int e = 0; e < 10; e++) begin
         @(posedge clk);
         #1;
         if (done_ee || done_ce || done_w1 || busy_ee || busy_ce) n++;
      end
      check("mid_reset no_done", n, 0);
      run_compare("after_reset 0f_0e", 8'h0F, 8'h0E, 1'b0, 1'b1, 1'b0, 1'b0, 8);

      // randomized operands against the reference model
      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom_range(0, 255));
         rs = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 2))
            0: rb = 8'($urandom_range(0, 255));
            1: rb = ra;
            default: rb = ra ^ (8'd1 << $urandom_range(0, 7));
         endcase
         rr = ref_cmp({56'd0, ra}, {56'd0, rb}, 8, rs);
         run_compare($sformatf("rand%0d_%h_%h_%0d", i, ra, rb, rs), ra, rb, rs,
                     rr[2], rr[1], rr[0], ref_k({56'd0, ra}, {56'd0, rb}, 8));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
